// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder/subtractor.
package adder_pkg;

  typedef enum logic [0:0] {
    IDLE,
    RUN
  } adder_state_t;

  localparam int ADDER_MIN_WIDTH = 2;
  localparam int ADDER_MAX_WIDTH = 64;

  // Bit-counter width: holds 0..WIDTH-1.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// Single-bit combinational full adder; one serial step of serial_adder.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor, LSB first, one bit per clock with a registered carry.
// Optional signed-overflow output ovf enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  if (WIDTH < ADDER_MIN_WIDTH || WIDTH > ADDER_MAX_WIDTH) begin : g_bad_width
    $error("serial_adder: WIDTH out of legal range");
  end

  adder_state_t     state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic fa_s;
  logic fa_co;

  full_adder_bit u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned (no latches).
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    done_d   = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d    = ovf_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          a_sh_d   = a;
          b_sh_d   = sub ? ~b : b;
          carry_d  = sub ? 1'b1 : cin;
          cnt_d    = '0;
          res_sh_d = '0;
        end
      end
      RUN: begin
        res_sh_d = {fa_s, res_sh_q[WIDTH-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = fa_co;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = IDLE;
          cnt_d   = '0;
          sum_d   = {fa_s, res_sh_q[WIDTH-1:1]};
          cout_d  = fa_co;
          done_d  = 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
          // Carry into the MSB is carry_q on the last step; carry out is fa_co.
          ovf_d   = carry_q ^ fa_co;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      done_q   <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign busy = (state_q == RUN);
  assign done = done_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): vector table plus hand-written corner sequences.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
  logic         done;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] last_sum;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .cin   (cin),
    .a     (a),
    .b     (b),
    .sum   (sum),
    .cout  (cout),
    .busy  (busy),
    .done  (done)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; start is seen by the next posedge (E0). Returns at the negedge after E0.
  task automatic issue(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vsub,
                       input logic vcin);
    start = 1'b1;
    a     = va;
    b     = vb;
    sub   = vsub;
    cin   = vcin;
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    sub   = 1'($urandom);
    cin   = 1'($urandom);
  endtask

  // Follows an operation from the negedge after E0 up to the done cycle (returns there).
  task automatic track(input string name, input logic [W-1:0] es, input logic ec, input logic eo,
                       input int inject_at);
    int busy_cnt = 0;
    int done_at  = -1;
    for (int i = 0; i < 3 * W; i++) begin
      if (i == inject_at) begin
        start = 1'b1;
        a     = 8'h33;
        b     = 8'h00;
        sub   = 1'b0;
      end else if (i == inject_at + 1) begin
        start = 1'b0;
      end
      if (busy) busy_cnt++;
      if (i == 3) check({name, "_no_partial_sum"}, 64'(sum), 64'(last_sum));
      if (done) begin
        done_at = i;
        break;
      end
      @(negedge clk);
    end
    check({name, "_done_cycle"}, 64'(done_at), 64'(W));
    check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(W));
    check({name, "_busy_with_done"}, 64'(busy), 64'd0);
    check({name, "_sum"}, 64'(sum), 64'(es));
    check({name, "_cout"}, 64'(cout), 64'(ec));
`ifdef SERIAL_ADDER_OVF_EN
    check({name, "_ovf"}, 64'(ovf), 64'(eo));
`else
    if (eo === 1'bx) $display("note: unexpected x in ovf expectation for %s", name);
`endif
    last_sum = es;
  endtask

  vec_t vecs[8];
  int   done_seen;

  initial begin
    vecs[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[2] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[6] = '{8'hA0, 8'h30, 1'b1, 1'b0, 8'h70, 1'b1, 1'b1};
    vecs[7] = '{8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    cin   = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_sum", 64'(sum), 64'd0);
    check("reset_cout", 64'(cout), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("reset_ovf", 64'(ovf), 64'd0);
`endif
    rst_n    = 1'b1;
    last_sum = '0;
    @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      issue(vecs[v].a, vecs[v].b, vecs[v].sub, vecs[v].cin);
      track($sformatf("vec%0d", v), vecs[v].exp_sum, vecs[v].exp_cout, vecs[v].exp_ovf, -1);
      @(negedge clk);
      check($sformatf("vec%0d_done_single", v), 64'(done), 64'd0);
    end

    // Start while busy is ignored; a start in the done cycle is accepted.
    issue(8'h10, 8'h20, 1'b0, 1'b0);
    track("ignore_start", 8'h30, 1'b0, 1'b0, 2);
    issue(8'h01, 8'h02, 1'b0, 1'b0);
    track("back_to_back", 8'h03, 1'b0, 1'b0, -1);
    @(negedge clk);

    // Reset in cycle 4 of an operation aborts it.
    issue(8'h55, 8'h11, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_sum", 64'(sum), 64'd0);
    check("midrst_cout", 64'(cout), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("midrst_ovf", 64'(ovf), 64'd0);
`endif
    last_sum  = '0;
    done_seen = 0;
    for (int i = 0; i < 2 * W; i++) begin
      if (done || busy) done_seen++;
      @(negedge clk);
    end
    check("midrst_no_done_after", 64'(done_seen), 64'd0);
    issue(8'h22, 8'h33, 1'b0, 1'b1);
    track("after_reset", 8'h56, 1'b0, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
